count_uart_reporter: RTL and testbench

Transmits the current two-digit up/down count as ASCII text over the board UART TX line, so a host terminal shows each new count value. Sits beside the 7-segment counter logic in the top level and samples the same tens/ones registers that drive the two display digits. Each report is sent whenever the count changes or on request. It is a self-contained 8N1 serial transmitter with its own message sequencer.

---
 rtl/count_uart_reporter.sv | 159 +++++++++++++++
 tb/tb_count_uart_reporter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/count_uart_reporter.sv
// 8N1 UART reporter: sends the two-digit BCD count as "TO\r\n"
// whenever the value changes or a resend is requested.
module count_uart_reporter #(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic [3:0] i_Tens,
   input  logic [3:0] i_Ones,
   input  logic       i_Send,
   output logic       o_Tx,
   output logic       o_Busy,
   output logic       o_Done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

   state_t      state, state_n;
   logic [15:0] baud_cnt, baud_cnt_n;
   logic [2:0]  bit_idx, bit_idx_n;
   logic [1:0]  byte_idx, byte_idx_n;
   logic [7:0]  msg, msg_n;
   logic [7:0]  last_sent, last_sent_n;
   logic        pending, pending_n;
   logic        tx, tx_n;
   logic        busy, busy_n;
   logic        done, done_n;
   logic [7:0]  cur_byte;
   logic        baud_end;
   logic        trigger;

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
   endfunction

   assign baud_end = (baud_cnt == BAUD_MAX);
   assign trigger  = ({i_Tens, i_Ones} != last_sent) || pending;

   always_comb begin
      cur_byte = 8'h0A;
      unique case (byte_idx)
         2'd0: cur_byte = digit_char(msg[7:4]);
         2'd1: cur_byte = digit_char(msg[3:0]);
         2'd2: cur_byte = 8'h0D;
         2'd3: cur_byte = 8'h0A;
      endcase
   end

   always_comb begin
      state_n     = state;
      baud_cnt_n  = baud_cnt;
      bit_idx_n   = bit_idx;
      byte_idx_n  = byte_idx;
      msg_n       = msg;
      last_sent_n = last_sent;
      pending_n   = pending | i_Send;
      tx_n        = tx;
      busy_n      = busy;
      done_n      = 1'b0;
      unique case (state)
         S_IDLE: begin
            tx_n   = 1'b1;
            busy_n = 1'b0;
            if (trigger) begin
               // Snapshot wins over a same-cycle i_Send: one message.
               state_n     = S_START;
               msg_n       = {i_Tens, i_Ones};
               last_sent_n = {i_Tens, i_Ones};
               pending_n   = 1'b0;
               baud_cnt_n  = 16'd0;
               bit_idx_n   = 3'd0;
               byte_idx_n  = 2'd0;
               tx_n        = 1'b0;
               busy_n      = 1'b1;
            end
         end
         S_START: begin
            if (baud_end) begin
               baud_cnt_n = 16'd0;
               bit_idx_n  = 3'd0;
               state_n    = S_DATA;
               tx_n       = cur_byte[0];
            end else begin
               baud_cnt_n = baud_cnt + 16'd1;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_cnt_n = 16'd0;
               if (bit_idx == 3'd7) begin
                  state_n = S_STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
                  tx_n      = cur_byte[bit_idx_n];
               end
            end else begin
               baud_cnt_n = baud_cnt + 16'd1;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               baud_cnt_n = 16'd0;
               if (byte_idx == 2'd3) begin
                  state_n = S_IDLE;
                  tx_n    = 1'b1;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  byte_idx_n = byte_idx + 2'd1;
                  state_n    = S_START;
                  tx_n       = 1'b0;
               end
            end else begin
               baud_cnt_n = baud_cnt + 16'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state     <= S_IDLE;
         baud_cnt  <= 16'd0;
         bit_idx   <= 3'd0;
         byte_idx  <= 2'd0;
         msg       <= 8'h00;
         last_sent <= 8'h00;
         pending   <= 1'b0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         baud_cnt  <= baud_cnt_n;
         bit_idx   <= bit_idx_n;
         byte_idx  <= byte_idx_n;
         msg       <= msg_n;
         last_sent <= last_sent_n;
         pending   <= pending_n;
         tx        <= tx_n;
         busy      <= busy_n;
         done      <= done_n;
      end
   end

   assign o_Tx   = tx;
   assign o_Busy = busy;
   assign o_Done = done;

endmodule

// File: tb/tb_count_uart_reporter.sv
// Directed bench for count_uart_reporter: decodes the serial line
// bit by bit and checks framing, timing, triggering and reset.
module tb_count_uart_reporter;

   localparam int CPB = 4;

   logic       i_Clk;
   logic       i_Rst;
   logic [3:0] i_Tens;
   logic [3:0] i_Ones;
   logic       i_Send;
   logic       o_Tx;
   logic       o_Busy;
   logic       o_Done;

   int n_cmp  = 0;
   int n_fail = 0;

   count_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clk  (i_Clk),
      .i_Rst  (i_Rst),
      .i_Tens (i_Tens),
      .i_Ones (i_Ones),
      .i_Send (i_Send),
      .o_Tx   (o_Tx),
      .o_Busy (o_Busy),
      .o_Done (o_Done)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_start(input int budget, output int waited);
      bit found;
      found  = 1'b0;
      waited = -1;
      for (int i = 1; i <= budget; i++) begin
         if (!found) begin
            @(negedge i_Clk);
            if (o_Tx === 1'b0) begin
               found  = 1'b1;
               waited = i;
            end
         end
      end
   endtask

   // Called at the negedge of the first start-bit cycle.
   task automatic recv_msg(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input string tag);
      logic [7:0] exp_b [4];
      logic [7:0] data;
      logic       v, s, start_v, stop_v, unstable;
      bit         first, busy_bad, done_bad;
      exp_b[0] = b0;
      exp_b[1] = b1;
      exp_b[2] = b2;
      exp_b[3] = b3;
      first    = 1'b1;
      busy_bad = 1'b0;
      done_bad = 1'b0;
      for (int by = 0; by < 4; by++) begin
         data     = 8'h00;
         start_v  = 1'b1;
         stop_v   = 1'b0;
         unstable = 1'b0;
         v        = 1'b0;
         for (int bt = 0; bt < 10; bt++) begin
            for (int c = 0; c < CPB; c++) begin
               if (!first) @(negedge i_Clk);
               first = 1'b0;
               s = o_Tx;
               if (c == 0) v = s;
               else if (s !== v) unstable = 1'b1;
               if (o_Busy !== 1'b1) busy_bad = 1'b1;
               if (o_Done !== 1'b0) done_bad = 1'b1;
            end
            if (bt == 0) start_v = v;
            else if (bt == 9) stop_v = v;
            else data[bt-1] = v;
         end
         check($sformatf("%s byte%0d data", tag, by), 32'(data),
               32'(exp_b[by]));
         check($sformatf("%s byte%0d start", tag, by), 32'(start_v), 0);
         check($sformatf("%s byte%0d stop", tag, by), 32'(stop_v), 1);
         check($sformatf("%s byte%0d bitlen", tag, by), 32'(unstable), 0);
      end
      check({tag, " busy during msg"}, 32'(busy_bad), 0);
      check({tag, " done during msg"}, 32'(done_bad), 0);
      @(negedge i_Clk);
      check({tag, " done pulse"}, 32'(o_Done), 1);
      check({tag, " busy at done"}, 32'(o_Busy), 0);
      check({tag, " tx at done"}, 32'(o_Tx), 1);
   endtask

   initial begin
      int w;
      int bad;
      i_Rst  = 1'b1;
      i_Tens = 4'd0;
      i_Ones = 4'd0;
      i_Send = 1'b0;
      repeat (3) @(negedge i_Clk);
      check("reset tx", 32'(o_Tx), 1);
      check("reset busy", 32'(o_Busy), 0);
      check("reset done", 32'(o_Done), 0);
      i_Rst = 1'b0;

      bad = 0;
      repeat (200) begin
         @(negedge i_Clk);
         if (o_Tx !== 1'b1 || o_Busy !== 1'b0) bad++;
      end
      check("idle 200 cycles", 32'(bad), 0);

      // "42" with mid-message changes to 43 then 44
      i_Tens = 4'd4;
      i_Ones = 4'd2;
      wait_start(50, w);
      check("42 start latency", 32'(w), 1);
      check("42 busy at start", 32'(o_Busy), 1);
      fork
         recv_msg(8'h34, 8'h32, 8'h0D, 8'h0A, "msg42");
         begin
            repeat (20) @(negedge i_Clk);
            i_Ones = 4'd3;
            repeat (10) @(negedge i_Clk);
            i_Ones = 4'd4;
         end
      join
      wait_start(50, w);
      check("44 back-to-back", 32'(w), 1);
      recv_msg(8'h34, 8'h34, 8'h0D, 8'h0A, "msg44");
      wait_start(30, w);
      check("no 43 msg", 32'(w), 32'hFFFF_FFFF);

      // "99" with two resend pulses during the message
      i_Tens = 4'd9;
      i_Ones = 4'd9;
      wait_start(50, w);
      check("99 start latency", 32'(w), 1);
      fork
         recv_msg(8'h39, 8'h39, 8'h0D, 8'h0A, "msg99a");
         begin
            repeat (30) @(negedge i_Clk);
            i_Send = 1'b1;
            @(negedge i_Clk);
            i_Send = 1'b0;
            repeat (30) @(negedge i_Clk);
            i_Send = 1'b1;
            @(negedge i_Clk);
            i_Send = 1'b0;
         end
      join
      wait_start(50, w);
      check("99 resend latency", 32'(w), 1);
      recv_msg(8'h39, 8'h39, 8'h0D, 8'h0A, "msg99b");
      wait_start(20, w);
      check("99 pulses collapsed", 32'(w), 32'hFFFF_FFFF);
      i_Send = 1'b1;
      @(negedge i_Clk);
      i_Send = 1'b0;
      wait_start(50, w);
      check("idle send latency", 32'(w), 1);
      recv_msg(8'h39, 8'h39, 8'h0D, 8'h0A, "msg99c");
      wait_start(30, w);
      check("no extra after send", 32'(w), 32'hFFFF_FFFF);

      i_Tens = 4'd0;
      i_Ones = 4'd0;
      wait_start(50, w);
      check("00 start latency", 32'(w), 1);
      recv_msg(8'h30, 8'h30, 8'h0D, 8'h0A, "msg00");

      i_Tens = 4'd10;
      i_Ones = 4'd15;
      wait_start(50, w);
      check("AF start latency", 32'(w), 1);
      recv_msg(8'h3F, 8'h3F, 8'h0D, 8'h0A, "msgAF");

      // reset during data bit 1 of byte 2
      i_Tens = 4'd1;
      i_Ones = 4'd2;
      wait_start(50, w);
      check("12 start latency", 32'(w), 1);
      repeat (89) @(negedge i_Clk);
      check("busy before reset", 32'(o_Busy), 1);
      i_Rst  = 1'b1;
      i_Tens = 4'd5;
      i_Ones = 4'd5;
      @(negedge i_Clk);
      i_Rst = 1'b0;
      check("mid reset tx", 32'(o_Tx), 1);
      check("mid reset busy", 32'(o_Busy), 0);
      check("mid reset done", 32'(o_Done), 0);
      wait_start(50, w);
      check("55 start latency", 32'(w), 1);
      recv_msg(8'h35, 8'h35, 8'h0D, 8'h0A, "msg55");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
